// File: rtl/freq_meas_sched.sv
// rtl/freq_meas_sched.sv - round-robin scheduler sharing one frequency-measurement core
module freq_meas_sched #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int CNT_W       = 28,
  parameter int GATE_CYC    = 99_999_999,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 250_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] pending,
  output logic [CH_W-1:0]   ch_sel,
  output logic              meas_start,
  output logic              meas_abort,
  output logic [CNT_W-1:0]  meas_gate_len,
  input  logic              meas_done,
  input  logic [CNT_W-1:0]  meas_cnt_clk,
  input  logic [CNT_W-1:0]  meas_cnt_squ,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [CNT_W-1:0]  res_cnt_clk,
  output logic [CNT_W-1:0]  res_cnt_squ,
  output logic              res_err,
  output logic              busy
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, OUT} state_t;

  state_t             state_q, state_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [CH_W-1:0]    ch_sel_q, ch_sel_d;
  logic [CH_W-1:0]    last_q, last_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               start_q, start_d;
  logic               abort_q, abort_d;
  logic               res_valid_q, res_valid_d;
  logic [CH_W-1:0]    res_ch_q, res_ch_d;
  logic [CNT_W-1:0]   res_clk_q, res_clk_d;
  logic [CNT_W-1:0]   res_squ_q, res_squ_d;
  logic               res_err_q, res_err_d;
  logic [CH_W-1:0]    winner;
  logic               found;

  // Round-robin search starting after the last served channel; lowest offset wins
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      logic [CH_W-1:0] idx;
      idx = CH_W'((int'(last_q) + k) % NUM_CH);
      if (pending_q[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state, pending latch and result capture
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ch_sel_d    = ch_sel_q;
    last_d      = last_q;
    set_cnt_d   = set_cnt_q;
    tmo_d       = tmo_q;
    start_d     = 1'b0;
    abort_d     = 1'b0;
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_clk_d   = res_clk_q;
    res_squ_d   = res_squ_q;
    res_err_d   = res_err_q;

    // Accepted result clears its channel; a simultaneous request re-sets it
    for (int i = 0; i < NUM_CH; i++) begin
      if (res_valid_q && res_ready && (res_ch_q == CH_W'(i))) pending_d[i] = 1'b0;
    end
    pending_d = pending_d | req;

    case (state_q)
      IDLE: begin
        if (found) begin
          ch_sel_d  = winner;
          last_d    = winner;
          set_cnt_d = '0;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (set_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
          start_d = 1'b1;
          state_d = START;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      START: begin
        // tmo counts cycles since the start pulse, so WAIT cycle n holds n
        tmo_d   = TMO_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (meas_done) begin
          res_clk_d   = meas_cnt_clk;
          res_squ_d   = meas_cnt_squ;
          res_ch_d    = ch_sel_q;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          abort_d     = 1'b1;
          res_clk_d   = '0;
          res_squ_d   = '0;
          res_ch_d    = ch_sel_q;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any measurement in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      ch_sel_q    <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
      set_cnt_q   <= '0;
      tmo_q       <= '0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_clk_q   <= '0;
      res_squ_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ch_sel_q    <= ch_sel_d;
      last_q      <= last_d;
      set_cnt_q   <= set_cnt_d;
      tmo_q       <= tmo_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_clk_q   <= res_clk_d;
      res_squ_q   <= res_squ_d;
      res_err_q   <= res_err_d;
    end
  end

  assign pending       = pending_q;
  assign ch_sel        = ch_sel_q;
  assign meas_start    = start_q;
  assign meas_abort    = abort_q;
  assign meas_gate_len = CNT_W'(GATE_CYC);
  assign res_valid     = res_valid_q;
  assign res_ch        = res_ch_q;
  assign res_cnt_clk   = res_clk_q;
  assign res_cnt_squ   = res_squ_q;
  assign res_err       = res_err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_freq_meas_sched.sv
// tb/tb_freq_meas_sched.sv - scoreboard bench for freq_meas_sched
module tb_freq_meas_sched;

  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int CNT_W   = 28;
  localparam int GATE    = 20;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 50;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] cclk;
    logic [CNT_W-1:0] csqu;
    logic             err;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] req = '0;
  logic [NUM_CH-1:0] pending;
  logic [CH_W-1:0]   ch_sel;
  logic              meas_start, meas_abort;
  logic [CNT_W-1:0]  meas_gate_len;
  logic              meas_done = 1'b0;
  logic [CNT_W-1:0]  meas_cnt_clk = '0;
  logic [CNT_W-1:0]  meas_cnt_squ = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [CH_W-1:0]   res_ch;
  logic [CNT_W-1:0]  res_cnt_clk, res_cnt_squ;
  logic              res_err, busy;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t exp_r, got_r;

  freq_meas_sched #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W),
    .GATE_CYC(GATE), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pending(pending), .ch_sel(ch_sel),
    .meas_start(meas_start), .meas_abort(meas_abort), .meas_gate_len(meas_gate_len),
    .meas_done(meas_done), .meas_cnt_clk(meas_cnt_clk), .meas_cnt_squ(meas_cnt_squ),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_cnt_clk(res_cnt_clk), .res_cnt_squ(res_cnt_squ), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // which: 0 = meas_start, 1 = meas_abort, 2 = res_valid; n = -1 when the bound expires
  task automatic wait_sig(input int which, output int n);
    logic s;
    n = 0;
    while (n < 200) begin
      s = (which == 0) ? meas_start : (which == 1) ? meas_abort : res_valid;
      if (s) return;
      tick();
      n++;
    end
    n = -1;
  endtask

  // Core returns done one cycle into WAIT
  task automatic serve(input int cv, input int sv);
    tick();
    meas_done    = 1'b1;
    meas_cnt_clk = CNT_W'(cv);
    meas_cnt_squ = CNT_W'(sv);
    tick();
    meas_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; meas_done = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pending, ch_sel, meas_start, meas_abort, res_valid, res_ch, res_cnt_clk,
         res_cnt_squ, res_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got pend=%b ch=%0d st=%b ab=%b v=%b busy=%b exp all zero",
               pending, ch_sel, meas_start, meas_abort, res_valid, busy);
    end
    checks++;
    if (meas_gate_len !== CNT_W'(GATE)) begin
      errors++;
      $display("FAIL gate_len got %0d exp %0d", meas_gate_len, GATE);
    end
  endtask

  task automatic test_single();
    int n;
    res_ready = 1'b1;
    req = 4'b0100;
    tick();
    req = '0;
    checks++;
    if (pending !== 4'b0100) begin
      errors++;
      $display("FAIL single_pending got %b exp 0100", pending);
    end
    wait_sig(0, n);
    checks++;
    if (n !== 5 || ch_sel !== 2'd2) begin
      errors++;
      $display("FAIL single_start got lat=%0d ch=%0d exp lat=5 ch=2", n, ch_sel);
    end
    sb.push_back(res_t'({2'd2, 28'd1000, 28'd10, 1'b0}));
    serve(1000, 10);
    checks++;
    got_r = {res_ch, res_cnt_clk, res_cnt_squ, res_err};
    exp_r = (sb.size() > 0) ? sb.pop_front() : '1;
    if (res_valid !== 1'b1 || got_r !== exp_r) begin
      errors++;
      $display("FAIL single_result got v=%b %h exp %h", res_valid, got_r, exp_r);
    end
    tick();
    checks++;
    if (pending[2] !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_accept got pend=%b v=%b busy=%b exp 0 0 0", pending, res_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic [CH_W-1:0] order[6];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    res_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j == 0) begin req = 4'b1111; tick(); req = '0; end
      if (j == 4) begin req = 4'b0011; tick(); req = '0; end
      wait_sig(0, n);
      sb.push_back(res_t'({order[j], CNT_W'(200 + j), CNT_W'(3 + j), 1'b0}));
      checks++;
      if (n < 0 || ch_sel !== order[j]) begin
        errors++;
        $display("FAIL rr_order[%0d] got ch=%0d lat=%0d exp ch=%0d", j, ch_sel, n, order[j]);
      end
      serve(200 + j, 3 + j);
      checks++;
      got_r = {res_ch, res_cnt_clk, res_cnt_squ, res_err};
      exp_r = (sb.size() > 0) ? sb.pop_front() : '1;
      if (res_valid !== 1'b1 || got_r !== exp_r) begin
        errors++;
        $display("FAIL rr_result[%0d] got v=%b %h exp %h", j, res_valid, got_r, exp_r);
      end
      tick();
    end
  endtask

  task automatic test_timeout_backpressure();
    int n, bad;
    res_t held;
    res_ready = 1'b0;
    req = 4'b1000;
    tick();
    req = '0;
    wait_sig(0, n);
    sb.push_back(res_t'({2'd3, 28'd0, 28'd0, 1'b1}));
    tick();
    wait_sig(1, n);
    checks++;
    if (n + 1 !== TIMEOUT) begin
      errors++;
      $display("FAIL abort_latency got %0d exp %0d", n + 1, TIMEOUT);
    end
    checks++;
    got_r = {res_ch, res_cnt_clk, res_cnt_squ, res_err};
    exp_r = (sb.size() > 0) ? sb.pop_front() : '1;
    if (res_valid !== 1'b1 || got_r !== exp_r) begin
      errors++;
      $display("FAIL timeout_result got v=%b %h exp %h", res_valid, got_r, exp_r);
    end
    held = got_r;
    req = 4'b0001;
    tick();
    req = '0;
    checks++;
    if (meas_abort !== 1'b0) begin
      errors++;
      $display("FAIL abort_width got %b exp 0", meas_abort);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (meas_start || !res_valid || {res_ch, res_cnt_clk, res_cnt_squ, res_err} !== held) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad);
    end
    res_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got busy=%b v=%b exp 0 0", busy, res_valid);
    end
    wait_sig(0, n);
    checks++;
    if (n !== SETTLE + 1 || ch_sel !== 2'd0) begin
      errors++;
      $display("FAIL bp_next_start got lat=%0d ch=%0d exp lat=%0d ch=0", n, ch_sel, SETTLE + 1);
    end
    serve(7, 7);
    tick();
  endtask

  task automatic test_collisions();
    int n, ab;
    res_ready = 1'b0;
    req = 4'b0010;
    tick();
    req = '0;
    wait_sig(0, n);
    serve(55, 5);
    res_ready = 1'b1;
    req = 4'b0010;
    tick();
    req = '0;
    checks++;
    if (pending[1] !== 1'b1) begin
      errors++;
      $display("FAIL collide_req_pending got %b exp 1", pending[1]);
    end
    sb.push_back(res_t'({2'd1, 28'd66, 28'd6, 1'b0}));
    wait_sig(0, n);
    checks++;
    if (n !== SETTLE + 1 || ch_sel !== 2'd1) begin
      errors++;
      $display("FAIL collide_remeasure got lat=%0d ch=%0d exp lat=%0d ch=1", n, ch_sel, SETTLE + 1);
    end
    serve(66, 6);
    checks++;
    got_r = {res_ch, res_cnt_clk, res_cnt_squ, res_err};
    exp_r = (sb.size() > 0) ? sb.pop_front() : '1;
    if (res_valid !== 1'b1 || got_r !== exp_r) begin
      errors++;
      $display("FAIL collide_result got v=%b %h exp %h", res_valid, got_r, exp_r);
    end
    tick();
    req = 4'b0100;
    tick();
    req = '0;
    wait_sig(0, n);
    sb.push_back(res_t'({2'd2, 28'd77, 28'd8, 1'b0}));
    ab = 0;
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      tick();
      if (meas_abort) ab++;
    end
    meas_done = 1'b1; meas_cnt_clk = 28'd77; meas_cnt_squ = 28'd8;
    tick();
    meas_done = 1'b0;
    if (meas_abort) ab++;
    checks++;
    got_r = {res_ch, res_cnt_clk, res_cnt_squ, res_err};
    exp_r = (sb.size() > 0) ? sb.pop_front() : '1;
    if (ab !== 0 || res_valid !== 1'b1 || got_r !== exp_r) begin
      errors++;
      $display("FAIL done_on_terminal got ab=%0d v=%b %h exp ab=0 %h", ab, res_valid, got_r, exp_r);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    int n, bad;
    res_ready = 1'b0;
    req = 4'b1100;
    tick();
    req = '0;
    wait_sig(0, n);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pending, ch_sel, meas_start, meas_abort, res_valid, res_ch, res_cnt_clk,
         res_cnt_squ, res_err, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset got pend=%b ch=%0d v=%b busy=%b exp all zero",
               pending, ch_sel, res_valid, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    meas_done = 1'b1; meas_cnt_clk = 28'd99; meas_cnt_squ = 28'd9;
    tick();
    meas_done = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (res_valid || meas_start || busy) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL late_done_ignored got %0d bad cycles exp 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout_backpressure();
    test_collisions();
    test_reset_in_wait();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
